// File: rtl/carregador_operandos.sv
// Operand loader for the 4-bit ALU: conditions the load button, then sequences A, B, op and
// offers them downstream with valid/ready. Define CARREGADOR_DEBOUNCE_EN to include the debounce counter.
module carregador_operandos #(
    parameter int LARGURA         = 4,
    parameter int OP_LARGURA      = 3,
    parameter int DEBOUNCE_CICLOS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [LARGURA-1:0]    entrada,
    input  logic [OP_LARGURA-1:0] op_sel,
    input  logic                  botao,
    input  logic                  ula_pronta,
    output logic [LARGURA-1:0]    A,
    output logic [LARGURA-1:0]    B,
    output logic [OP_LARGURA-1:0] op,
    output logic                  valido,
    output logic [1:0]            estado
);

    localparam logic [1:0] ESPERA_A  = 2'b00;
    localparam logic [1:0] ESPERA_B  = 2'b01;
    localparam logic [1:0] ESPERA_OP = 2'b10;
    localparam logic [1:0] PRONTO    = 2'b11;

    logic s1_q, s1_d;
    logic s2_q, s2_d;
    logic estavel;
    logic estavel_ant_q, estavel_ant_d;
    logic pulso;

    assign s1_d          = botao;
    assign s2_d          = s1_q;
    assign estavel_ant_d = estavel;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            estavel_ant_q <= 1'b0;
        end else begin
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            estavel_ant_q <= estavel_ant_d;
        end
    end

`ifdef CARREGADOR_DEBOUNCE_EN
    localparam int CW = (DEBOUNCE_CICLOS > 1) ? $clog2(DEBOUNCE_CICLOS + 1) : 1;

    logic [CW-1:0] cont_q, cont_d;
    logic          estavel_q, estavel_d;

    // Flip on the edge the counter would reach DEBOUNCE_CICLOS, so the level needs that many mismatching edges.
    always_comb begin
        cont_d    = '0;
        estavel_d = estavel_q;
        if (s2_q != estavel_q) begin
            if (cont_q == CW'(DEBOUNCE_CICLOS - 1)) begin
                estavel_d = s2_q;
            end else begin
                cont_d = cont_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cont_q    <= '0;
            estavel_q <= 1'b0;
        end else begin
            cont_q    <= cont_d;
            estavel_q <= estavel_d;
        end
    end

    assign estavel = estavel_q;
`else
    assign estavel = s2_q;
`endif

    assign pulso = estavel & ~estavel_ant_q;

    logic [1:0]            estado_q, estado_d;
    logic [LARGURA-1:0]    a_q, a_d;
    logic [LARGURA-1:0]    b_q, b_d;
    logic [OP_LARGURA-1:0] op_q, op_d;
    logic                  valido_q, valido_d;

    // PRONTO only watches ula_pronta, so a press there is dropped rather than queued.
    always_comb begin
        estado_d = estado_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        valido_d = valido_q;
        case (estado_q)
            ESPERA_A: begin
                if (pulso) begin
                    a_d      = entrada;
                    estado_d = ESPERA_B;
                end
            end
            ESPERA_B: begin
                if (pulso) begin
                    b_d      = entrada;
                    estado_d = ESPERA_OP;
                end
            end
            ESPERA_OP: begin
                if (pulso) begin
                    op_d     = op_sel;
                    valido_d = 1'b1;
                    estado_d = PRONTO;
                end
            end
            PRONTO: begin
                if (ula_pronta) begin
                    valido_d = 1'b0;
                    estado_d = ESPERA_A;
                end
            end
            default: begin
                valido_d = 1'b0;
                estado_d = ESPERA_A;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q <= ESPERA_A;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            valido_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            valido_q <= valido_d;
        end
    end

    assign A      = a_q;
    assign B      = b_q;
    assign op     = op_q;
    assign valido = valido_q;
    assign estado = estado_q;

endmodule
